baccarat_dealer: RTL and testbench

//  Dealing sequencer for one baccarat round; sits directly upstream of the scorehand instances.

---
 rtl/baccarat_pkg.sv | 23 ++
 rtl/banker_draw_rule.sv | 22 ++
 rtl/baccarat_dealer.sv | 129 ++++++++++++
 tb/tb_baccarat_dealer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat dealing sequencer.
package baccarat_pkg;

  typedef enum logic [3:0] {IDLE, P1, D1, P2, D2, EVAL, P3, D3C, D3, DONE} dealer_state_t;

  typedef logic [3:0] card_t;

  localparam card_t NATURAL_MIN = 4'd8;
  localparam card_t DRAW_MAX    = 4'd5;

  // Point value of a card: 10..13 (and out-of-range codes 14, 15) count as zero.
  function automatic card_t card_val(input card_t c);
    return (c >= 4'd10) ? 4'd0 : c;
  endfunction

  function automatic card_t add_mod10(input card_t a, input card_t b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Third-card tableau for the banker once the player has drawn; purely combinational.
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  card_t dscore,
  input  card_t v,
  output logic  draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_dealer.sv
// Baccarat round sequencer: deals six hand registers, applies the tableau, flags the winner.
// Optional round statistics counters are compiled in with `define BACC_STATS_EN.
module baccarat_dealer
  import baccarat_pkg::*;
#(
  parameter int STAT_W = 8
) (
  input  logic  slow_clock,
  input  logic  resetb,
  input  logic  start,
  input  card_t card_in,
  input  logic  card_valid,
  output logic  card_ready,
  output card_t pcard1,
  output card_t pcard2,
  output card_t pcard3,
  output card_t dcard1,
  output card_t dcard2,
  output card_t dcard3,
  input  card_t pscore,
  input  card_t dscore,
  output logic  player_win,
  output logic  dealer_win,
  output logic  done
`ifdef BACC_STATS_EN
  ,
  output logic [STAT_W-1:0] player_wins,
  output logic [STAT_W-1:0] dealer_wins,
  output logic [STAT_W-1:0] ties
`endif
);

  dealer_state_t state, state_nx;
  logic  restart, xfer, draw, enter_done;
  card_t v3, dscore_fin;

  assign restart    = start && ((state == IDLE) || (state == DONE));
  assign xfer       = card_ready && card_valid;
  assign v3         = card_val(pcard3);
  assign enter_done = (state_nx == DONE) && (state != DONE);
  // Entering DONE from D3 happens on the same edge that loads dcard3, so the
  // external dscore does not yet include it; fold the incoming card in here.
  assign dscore_fin = (state == D3) ? add_mod10(dscore, card_val(card_in)) : dscore;

  banker_draw_rule u_banker_draw_rule (
    .dscore (dscore),
    .v      (v3),
    .draw   (draw)
  );

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    card_ready = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_nx = P1;
      P1:   begin card_ready = 1'b1; if (card_valid) state_nx = D1;   end
      D1:   begin card_ready = 1'b1; if (card_valid) state_nx = P2;   end
      P2:   begin card_ready = 1'b1; if (card_valid) state_nx = D2;   end
      D2:   begin card_ready = 1'b1; if (card_valid) state_nx = EVAL; end
      EVAL: begin
        if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) state_nx = DONE;
        else if (pscore <= DRAW_MAX)                             state_nx = P3;
        else if (dscore <= DRAW_MAX)                             state_nx = D3;
        else                                                     state_nx = DONE;
      end
      P3:   begin card_ready = 1'b1; if (card_valid) state_nx = D3C;  end
      D3C:  state_nx = draw ? D3 : DONE;
      D3:   begin card_ready = 1'b1; if (card_valid) state_nx = DONE; end
      DONE: begin done = 1'b1; if (start) state_nx = P1; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} <= '0;
    end else if (restart) begin
      {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} <= '0;
    end else if (xfer) begin
      case (state)
        P1:      pcard1 <= card_in;
        D1:      dcard1 <= card_in;
        P2:      pcard2 <= card_in;
        D2:      dcard2 <= card_in;
        P3:      pcard3 <= card_in;
        D3:      dcard3 <= card_in;
        default: ;
      endcase
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_win <= 1'b0;
      dealer_win <= 1'b0;
    end else if (restart) begin
      player_win <= 1'b0;
      dealer_win <= 1'b0;
    end else if (enter_done) begin
      player_win <= (pscore >= dscore_fin);
      dealer_win <= (dscore_fin >= pscore);
    end
  end

`ifdef BACC_STATS_EN
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      player_wins <= '0;
      dealer_wins <= '0;
      ties        <= '0;
    end else if (enter_done) begin
      if (pscore == dscore_fin) begin
        if (ties != '1) ties <= ties + 1'b1;
      end else if (pscore > dscore_fin) begin
        if (player_wins != '1) player_wins <= player_wins + 1'b1;
      end else begin
        if (dealer_wins != '1) dealer_wins <= dealer_wins + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_baccarat_dealer.sv
// Bench for baccarat_dealer: scorehand model, directed round table, corner sequences, random rounds.
module tb_baccarat_dealer;
  import baccarat_pkg::*;

  logic  slow_clock = 1'b0;
  logic  resetb = 1'b0;
  logic  start = 1'b0;
  logic  card_valid = 1'b0;
  card_t card_in = 4'd0;
  logic  card_ready, player_win, dealer_win, done;
  card_t pcard1, pcard2, pcard3, dcard1, dcard2, dcard3, pscore, dscore;
`ifdef BACC_STATS_EN
  logic [1:0] player_wins, dealer_wins, ties;
`endif

  always #5 slow_clock = ~slow_clock;

  function automatic int cv(input card_t c);
    return (c >= 4'd10) ? 0 : int'(c);
  endfunction

  // Scorehand stand-ins: hand total modulo ten.
  assign pscore = card_t'((cv(pcard1) + cv(pcard2) + cv(pcard3)) % 10);
  assign dscore = card_t'((cv(dcard1) + cv(dcard2) + cv(dcard3)) % 10);

  baccarat_dealer #(.STAT_W(2)) dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .start       (start),
    .card_in     (card_in),
    .card_valid  (card_valid),
    .card_ready  (card_ready),
    .pcard1      (pcard1),
    .pcard2      (pcard2),
    .pcard3      (pcard3),
    .dcard1      (dcard1),
    .dcard2      (dcard2),
    .dcard3      (dcard3),
    .pscore      (pscore),
    .dscore      (dscore),
    .player_win  (player_win),
    .dealer_win  (dealer_win),
    .done        (done)
`ifdef BACC_STATS_EN
    ,
    .player_wins (player_wins),
    .dealer_wins (dealer_wins),
    .ties        (ties)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    card_t deck[6];
    card_t p1, d1, p2, d2, p3, d3;
    logic  pw, dw;
    int    lat;
  } rnd_t;

  function automatic rnd_t mk(input int c0, c1, c2, c3, c4, c5,
                              input int p1, d1, p2, d2, p3, d3,
                              input int pw, dw, lat);
    rnd_t r;
    r.deck[0] = card_t'(c0); r.deck[1] = card_t'(c1); r.deck[2] = card_t'(c2);
    r.deck[3] = card_t'(c3); r.deck[4] = card_t'(c4); r.deck[5] = card_t'(c5);
    r.p1 = card_t'(p1); r.d1 = card_t'(d1); r.p2 = card_t'(p2);
    r.d2 = card_t'(d2); r.p3 = card_t'(p3); r.d3 = card_t'(d3);
    r.pw = pw[0]; r.dw = dw[0]; r.lat = lat;
    return r;
  endfunction

  // Plays a baccarat round straight from the rules of the game.
  function automatic rnd_t model(input card_t deck[6]);
    rnd_t r;
    int ps, ds, v;
    logic draw;
    r.deck = deck;
    r.p1 = deck[0]; r.d1 = deck[1]; r.p2 = deck[2]; r.d2 = deck[3];
    r.p3 = 4'd0; r.d3 = 4'd0; r.lat = 6;
    ps = (cv(deck[0]) + cv(deck[2])) % 10;
    ds = (cv(deck[1]) + cv(deck[3])) % 10;
    if (!(ps >= 8 || ds >= 8)) begin
      if (ps <= 5) begin
        r.p3 = deck[4]; v = cv(deck[4]); ps = (ps + v) % 10; r.lat = 8;
        if (ds <= 2)      draw = 1'b1;
        else if (ds == 3) draw = (v != 8);
        else if (ds <= 6) draw = (v >= 2 * (ds - 3)) && (v <= 7);
        else              draw = 1'b0;
        if (draw) begin
          r.d3 = deck[5]; ds = (ds + cv(deck[5])) % 10; r.lat = 9;
        end
      end else if (ds <= 5) begin
        r.d3 = deck[4]; ds = (ds + cv(deck[4])) % 10; r.lat = 7;
      end
    end
    r.pw = (ps >= ds);
    r.dw = (ds >= ps);
    return r;
  endfunction

  task automatic play(input rnd_t e, input bit stall, input string tag);
    int   k = 0;
    int   edges;
    logic xf;
    @(negedge slow_clock);
    start = 1'b1;
    @(posedge slow_clock);
    #1 start = 1'b0;
    edges = 1;
    while (!done && edges < 80) begin
      card_in    = (k < 6) ? e.deck[k] : 4'd0;
      card_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge slow_clock);
      xf = card_ready & card_valid;
      @(posedge slow_clock);
      #1 edges++;
      if (xf) k++;
    end
    card_valid = 1'b0;
    check({tag, ".done"}, done, 1);
    if (!stall) check({tag, ".latency"}, edges, e.lat);
    check({tag, ".pcard1"}, pcard1, e.p1);
    check({tag, ".dcard1"}, dcard1, e.d1);
    check({tag, ".pcard2"}, pcard2, e.p2);
    check({tag, ".dcard2"}, dcard2, e.d2);
    check({tag, ".pcard3"}, pcard3, e.p3);
    check({tag, ".dcard3"}, dcard3, e.d3);
    check({tag, ".player_win"}, player_win, e.pw);
    check({tag, ".dealer_win"}, dealer_win, e.dw);
  endtask

  rnd_t tbl[7];

  initial begin
    rnd_t  r;
    card_t dk[6];

    tbl[0] = mk(9, 2, 13, 3, 0, 0,   9, 2, 13, 3, 0, 0,   1, 0, 6);
    tbl[1] = mk(2, 3, 1, 4, 5, 7,    2, 3, 1, 4, 5, 0,    1, 0, 8);
    tbl[2] = mk(1, 2, 2, 2, 8, 0,    1, 2, 2, 2, 8, 0,    0, 1, 8);
    tbl[3] = mk(2, 1, 3, 2, 7, 4,    2, 1, 3, 2, 7, 4,    0, 1, 9);
    tbl[4] = mk(3, 2, 4, 5, 0, 0,    3, 2, 4, 5, 0, 0,    1, 1, 6);
    tbl[5] = mk(6, 1, 1, 2, 5, 0,    6, 1, 1, 2, 0, 5,    0, 1, 7);
    tbl[6] = mk(14, 0, 15, 3, 9, 2,  14, 0, 15, 3, 9, 2,  1, 0, 9);

    #1;
    check("reset.card_ready", card_ready, 0);
    check("reset.done", done, 0);
    check("reset.flags", {player_win, dealer_win}, 0);
    check("reset.cards", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
    @(negedge slow_clock);
    resetb = 1'b1;
    repeat (2) @(posedge slow_clock);
    #1 check("idle.card_ready", card_ready, 0);

    for (int i = 0; i < 7; i++) play(tbl[i], 1'b0, $sformatf("dir%0d", i));

    // Deck stall in D1, then start ignored in EVAL, then reset during P3.
    @(negedge slow_clock);
    start = 1'b1;
    @(posedge slow_clock);
    #1 start = 1'b0;
    card_in = 4'd9; card_valid = 1'b1;
    @(posedge slow_clock);
    #1 card_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge slow_clock);
      #1 check($sformatf("stall%0d.card_ready", i), card_ready, 1);
      check($sformatf("stall%0d.dcard1", i), dcard1, 0);
    end
    card_in = 4'd6; card_valid = 1'b1;
    @(posedge slow_clock);
    #1 card_valid = 1'b0;
    check("stall.dcard1_loaded", dcard1, 6);
    check("stall.pcard2_untouched", pcard2, 0);
    @(posedge slow_clock);
    #1 check("stall.no_skip", pcard2, 0);
    card_in = 4'd2; card_valid = 1'b1;
    @(posedge slow_clock);
    #1 card_in = 4'd1;
    @(posedge slow_clock);
    #1 card_valid = 1'b0;
    start = 1'b1;
    @(posedge slow_clock);
    #1 start = 1'b0;
    check("eval_start.pcard1_kept", pcard1, 9);
    check("eval_start.in_p3", card_ready, 1);
    check("eval_start.done", done, 0);
    #2 resetb = 1'b0;
    #1;
    check("midp3_reset.cards", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3}, 0);
    check("midp3_reset.ctrl", {card_ready, done, player_win, dealer_win}, 0);
    @(negedge slow_clock);
    resetb = 1'b1;
    @(posedge slow_clock);
    #1 check("midp3_reset.idle", card_ready, 0);

    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < 6; j++) begin
        if ($urandom_range(0, 19) == 0) dk[j] = card_t'($urandom_range(14, 16) % 16);
        else                            dk[j] = card_t'($urandom_range(1, 13));
      end
      r = model(dk);
      play(r, i[0], $sformatf("rnd%0d", i));
    end

`ifdef BACC_STATS_EN
    @(negedge slow_clock);
    resetb = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
    for (int i = 0; i < 4; i++) play(tbl[0], 1'b0, $sformatf("stat%0d", i));
    check("stats.player_wins", player_wins, 3);
    check("stats.dealer_wins", dealer_wins, 0);
    check("stats.ties", ties, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
